uart_block_cipher_bridge: RTL

- Serial-to-block-cipher bridge, parametrised in block width.
- Packs BLOCK_BYTES received UART bytes into one block and drives a cipher core (des56-style ds/rdy handshake, with its own reset pulse).
- Captures the result and streams it back byte by byte through the UART transmitter.
- Sits between async_receiver/async_transmitter and the cipher core. It adds an inter-byte timeout, overrun detection, per-block mode select and status outputs.

---
 rtl/cipher_bridge_pkg.sv | 26 ++
 rtl/bridge_timeout_ctr.sv | 29 ++
 rtl/uart_block_cipher_bridge.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cipher_bridge_pkg.sv
// Shared types and helpers for the UART-to-block-cipher bridge.
package cipher_bridge_pkg;

  localparam int BYTE_W = 8;
  // Widest block the byte-select helper accepts; callers zero-extend into it.
  localparam int MAX_BLOCK_W = 2048;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CORE_RST,
    LAUNCH,
    WAIT_RDY,
    SEND,
    SEND_HOLD
  } stateT;

  // Returns byte k of a block; byte 0 is the least-significant byte.
  function automatic logic [BYTE_W-1:0] blockByte(input logic [MAX_BLOCK_W-1:0] blk,
                                                  input int unsigned k);
    logic [MAX_BLOCK_W-1:0] shifted;
    shifted = blk >> (k * BYTE_W);
    return shifted[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Loadable down-counter. expire is high during the enabled cycle in which
// the count would reach zero; a load in the same cycle takes precedence.
module bridge_timeout_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] loadVal,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Count down while enabled, reload on request, stick at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && !load && (count == WIDTH'(1));

endmodule

// File: rtl/uart_block_cipher_bridge.sv
// Packs received UART bytes into a cipher block, runs the cipher core through
// its rst/ds/rdy handshake and streams the result back out byte 0 first.
// Optional macro DEBUG_TAP_EN adds a registered byte tap (dbg_sel/dbg_led).
module uart_block_cipher_bridge
  import cipher_bridge_pkg::*;
#(
  parameter int BLOCK_BYTES     = 8,
  parameter int RX_TIMEOUT      = 1000000,
  parameter int CORE_RST_CYCLES = 4,
  parameter int CORE_TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_data_ready,
  input  logic [7:0]                    rx_data,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          tx_busy,
  input  logic                          mode_in,
  output logic [BLOCK_BYTES*BYTE_W-1:0] core_in,
  output logic                          core_decipher,
  output logic                          core_rst,
  output logic                          core_ds,
  input  logic                          core_rdy,
  input  logic [BLOCK_BYTES*BYTE_W-1:0] core_out,
  output logic                          busy,
  output logic                          err_timeout,
  output logic                          err_overrun,
  output logic [15:0]                   blocks_done
`ifdef DEBUG_TAP_EN
  ,
  input  logic [$clog2(BLOCK_BYTES)-1:0] dbg_sel,
  output logic [7:0]                     dbg_led
`endif
);

  localparam int BLOCK_W = BLOCK_BYTES * BYTE_W;
  localparam int IDX_W   = $clog2(BLOCK_BYTES + 1);
  localparam int RST_W   = $clog2(CORE_RST_CYCLES + 1);
  localparam int RXT_W   = $clog2(RX_TIMEOUT + 2);
  localparam int CT_W    = $clog2(CORE_TIMEOUT + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(CORE_RST_CYCLES - 1);

  stateT              state, stateNext;
  logic [IDX_W-1:0]   idx;
  logic [RST_W-1:0]   rstCnt;
  logic               holdArmed;
  logic [BLOCK_W-1:0] dataReg;
  logic [BLOCK_W-1:0] bufReg;
  logic               coreDecipher;
  logic [15:0]        blocksDone;

  logic storeByte, captureOut, advanceIdx, finishBlk;
  logic rxTimerEn, rxExpire, coreExpire;

  // The idle timer only runs in COLLECT; a strobe reloads it and wins over expiry.
  assign rxTimerEn = (RX_TIMEOUT != 0) && (state == COLLECT) && !rx_data_ready;

  bridge_timeout_ctr #(.WIDTH(RXT_W)) rxTimer (
    .clk    (clk),
    .rst    (rst),
    .load   (storeByte),
    .enable (rxTimerEn),
    .loadVal(RXT_W'(RX_TIMEOUT)),
    .expire (rxExpire)
  );

  bridge_timeout_ctr #(.WIDTH(CT_W)) coreTimer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == LAUNCH),
    .enable (state == WAIT_RDY),
    .loadVal(CT_W'(CORE_TIMEOUT)),
    .expire (coreExpire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state decode and per-cycle control/status strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    stateNext   = state;
    storeByte   = 1'b0;
    captureOut  = 1'b0;
    advanceIdx  = 1'b0;
    finishBlk   = 1'b0;
    tx_start    = 1'b0;
    tx_data     = '0;
    err_timeout = 1'b0;
    err_overrun = 1'b0;
    case (state)
      IDLE: begin
        if (rx_data_ready) begin
          storeByte = 1'b1;
          stateNext = (BLOCK_BYTES == 1) ? CORE_RST : COLLECT;
        end
      end
      COLLECT: begin
        if (rx_data_ready) begin
          storeByte = 1'b1;
          if (idx == LAST_IDX) stateNext = CORE_RST;
        end else if (rxExpire) begin
          err_timeout = 1'b1;
          stateNext   = IDLE;
        end
      end
      CORE_RST: begin
        err_overrun = rx_data_ready;
        if (rstCnt == RST_LAST) stateNext = LAUNCH;
      end
      LAUNCH: begin
        err_overrun = rx_data_ready;
        stateNext   = WAIT_RDY;
      end
      WAIT_RDY: begin
        err_overrun = rx_data_ready;
        if (core_rdy) begin
          captureOut = 1'b1;
          stateNext  = SEND;
        end else if (coreExpire) begin
          err_timeout = 1'b1;
          stateNext   = IDLE;
        end
      end
      SEND: begin
        err_overrun = rx_data_ready;
        tx_data     = blockByte(MAX_BLOCK_W'(bufReg), 32'(idx));
        if (!tx_busy) begin
          tx_start  = 1'b1;
          stateNext = SEND_HOLD;
        end
      end
      SEND_HOLD: begin
        err_overrun = rx_data_ready;
        // The first cycle here is skipped so the transmitter can raise tx_busy.
        if (holdArmed && !tx_busy) begin
          advanceIdx = 1'b1;
          if (idx == LAST_IDX) begin
            finishBlk = 1'b1;
            stateNext = IDLE;
          end else begin
            stateNext = SEND;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Byte index, core reset timer, block buffers and block counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the block buffers are reset because they drive core_in and
      // tx_data directly; a plain storage array would not need it.
      dataReg      <= '0;
      bufReg       <= '0;
      idx          <= '0;
      rstCnt       <= '0;
      holdArmed    <= 1'b0;
      coreDecipher <= 1'b0;
      blocksDone   <= '0;
    end else begin
      rstCnt    <= (state == CORE_RST) ? rstCnt + 1'b1 : '0;
      holdArmed <= (state == SEND_HOLD);
      if ((state == IDLE) && rx_data_ready) coreDecipher <= mode_in;
      if (storeByte) begin
        for (int k = 0; k < BLOCK_BYTES; k++) begin
          if (idx == IDX_W'(k)) dataReg[k*BYTE_W +: BYTE_W] <= rx_data;
        end
      end
      if (captureOut) bufReg <= core_out;
      if ((stateNext == IDLE) || captureOut)  idx <= '0;
      else if (storeByte || advanceIdx)       idx <= idx + 1'b1;
      if (finishBlk) blocksDone <= blocksDone + 1'b1;
    end
  end

  assign core_in       = dataReg;
  assign core_decipher = coreDecipher;
  assign core_rst      = (state == CORE_RST);
  assign core_ds       = (state == LAUNCH) || (state == WAIT_RDY);
  assign busy          = (state != IDLE);
  assign blocks_done   = blocksDone;

`ifdef DEBUG_TAP_EN
  // Registered view of one selected byte of the assembled block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbg_led <= '0;
    else     dbg_led <= blockByte(MAX_BLOCK_W'(dataReg), 32'(dbg_sel));
  end
`endif

endmodule
